// File: rtl/glitch_pkg.sv
// glitch_pkg: shared types for the glitch scheduler.
//   state_e    - scheduler state encoding.
//   slot_cfg_t - slot configuration word {en, cycle, delay, width}, MSB first,
//                laid out for the default widths. Modules built with other
//                widths declare a local struct with the same field order.
//   CFG_W      - width of slot_cfg_t (and of cfg_wdata at default widths).
package glitch_pkg;

  localparam int DEF_CYC_W = 16;
  localparam int DEF_TAP_W = 4;
  localparam int CFG_W     = 1 + DEF_CYC_W + 2 * DEF_TAP_W;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN,
    DONE
  } state_e;

  typedef struct packed {
    logic                 en;
    logic [DEF_CYC_W-1:0] cycle;
    logic [DEF_TAP_W-1:0] delay;
    logic [DEF_TAP_W-1:0] width;
  } slot_cfg_t;

endpackage

// File: rtl/glitch_slot_match.sv
// glitch_slot_match: one glitch slot. Holds the slot configuration and a
// per-run fired flag, and reports a match when the slot is enabled, has not
// fired this run, and its cycle equals the count the scheduler will show in
// the coming cycle.
//   clk, rst_n - clock, asynchronous active-low reset
//   we         - load wdata into the slot register
//   wdata      - {en, cycle, delay, width}
//   clear      - clear the fired flag (run start)
//   eval       - the scheduler will be in RUN next cycle
//   cnt_next   - cycle count for the next cycle
//   match      - slot fires in the next cycle
//   delay      - stored delay tap
//   width      - stored width tap
module glitch_slot_match
  import glitch_pkg::*;
#(
  parameter  int CYC_W = DEF_CYC_W,
  parameter  int TAP_W = DEF_TAP_W,
  localparam int WD_W  = 1 + CYC_W + 2 * TAP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WD_W-1:0]  wdata,
  input  logic             clear,
  input  logic             eval,
  input  logic [CYC_W-1:0] cnt_next,
  output logic             match,
  output logic [TAP_W-1:0] delay,
  output logic [TAP_W-1:0] width
);

  typedef struct packed {
    logic             en;
    logic [CYC_W-1:0] cycle;
    logic [TAP_W-1:0] delay;
    logic [TAP_W-1:0] width;
  } slot_t;

  slot_t slot_q;
  logic  fired_q;

  // NOTE: the slot register is a handful of flops, not a RAM, so it is reset;
  // after reset every slot must read as disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      fired_q <= 1'b0;
    end else begin
      if (we) slot_q <= wdata;
      if (clear)      fired_q <= 1'b0;
      else if (match) fired_q <= 1'b1;
    end
  end

  assign match = eval && slot_q.en && !fired_q && (slot_q.cycle == cnt_next);
  assign delay = slot_q.delay;
  assign width = slot_q.width;

endmodule

// File: rtl/glitch_scheduler.sv
// glitch_scheduler: fault-injection sequencer. After arm, waits for a rising
// edge on trigger, then counts cycles and emits a one-cycle fire strobe with
// the slot's delay/width taps when the count reaches a slot's cycle offset.
//   clk, rst_n      - reference clock, asynchronous active-low reset
//   cfg_we/addr/wdata - slot write {en, cycle, delay, width}; IDLE/DONE only
//   arm, abort      - run start / return to IDLE (abort wins)
//   trigger         - DUT trigger GPIO, synchronous to clk
//   fire, fire_delay, fire_width - glitch strobe and taps (taps 0 when idle)
//   cycle_cnt       - cycles since trigger rising edge
//   busy, done      - ARMED/RUN, DONE
//   fired_cnt       - glitches emitted this run (saturating)
//   collision       - sticky: several slots matched in one cycle
//   overflow        - sticky: cycle_cnt saturated while trigger was high
module glitch_scheduler
  import glitch_pkg::*;
#(
  parameter  int NUM_SLOTS = 2,
  parameter  int CYC_W     = DEF_CYC_W,
  parameter  int TAP_W     = DEF_TAP_W,
  localparam int ADDR_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int WD_W      = 1 + CYC_W + 2 * TAP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [WD_W-1:0]   cfg_wdata,
  input  logic              arm,
  input  logic              abort,
  input  logic              trigger,
  output logic              fire,
  output logic [TAP_W-1:0]  fire_delay,
  output logic [TAP_W-1:0]  fire_width,
  output logic [CYC_W-1:0]  cycle_cnt,
  output logic              busy,
  output logic              done,
  output logic [3:0]        fired_cnt,
  output logic              collision,
  output logic              overflow
);

  state_e           state_q, state_d;
  logic             trigger_q;
  logic [CYC_W-1:0] cnt_d;
  logic             start;
  logic             set_ovf;
  logic             eval;
  logic             cfg_ok;
  logic             multi;

  logic [NUM_SLOTS-1:0] match;
  logic [TAP_W-1:0]     slot_delay [NUM_SLOTS];
  logic [TAP_W-1:0]     slot_width [NUM_SLOTS];
  logic [TAP_W-1:0]     sel_delay, sel_width;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cycle_cnt;
    start   = 1'b0;
    set_ovf = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            state_d = ARMED;
            start   = 1'b1;
          end
        end
        ARMED: begin
          if (trigger && !trigger_q) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN: begin
          if (!trigger) begin
            state_d = DONE;
          end else if (&cycle_cnt) begin
            state_d = DONE;
            set_ovf = 1'b1;
          end else begin
            cnt_d = cycle_cnt + CYC_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (start) cnt_d = '0;
  end

  // Slots compare against the count of the coming cycle and only when that
  // cycle is a RUN cycle, so fire lines up with cycle_cnt and a trigger fall
  // suppresses the strobe.
  assign eval   = (state_d == RUN);
  assign cfg_ok = cfg_we && ((state_q == IDLE) || (state_q == DONE));
  assign multi  = (match & (match - NUM_SLOTS'(1))) != '0;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    glitch_slot_match #(
      .CYC_W (CYC_W),
      .TAP_W (TAP_W)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (cfg_ok && (cfg_addr == ADDR_W'(i))),
      .wdata    (cfg_wdata),
      .clear    (start),
      .eval     (eval),
      .cnt_next (cnt_d),
      .match    (match[i]),
      .delay    (slot_delay[i]),
      .width    (slot_width[i])
    );
  end

  // Walk from the top so the lowest matching index is the last to assign.
  always_comb begin
    sel_delay = '0;
    sel_width = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel_delay = slot_delay[i];
        sel_width = slot_width[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      trigger_q  <= 1'b0;
      cycle_cnt  <= '0;
      fire       <= 1'b0;
      fire_delay <= '0;
      fire_width <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fired_cnt  <= '0;
      collision  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      trigger_q  <= trigger;
      cycle_cnt  <= cnt_d;
      fire       <= |match;
      fire_delay <= sel_delay;
      fire_width <= sel_width;
      busy       <= (state_d == ARMED) || (state_d == RUN);
      done       <= (state_d == DONE);
      if (start) begin
        fired_cnt <= '0;
        collision <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        if (|match && (fired_cnt != 4'hF)) fired_cnt <= fired_cnt + 4'd1;
        if (multi)   collision <= 1'b1;
        if (set_ovf) overflow  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_glitch_scheduler.sv
module tb_glitch_scheduler;
  import glitch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default-width instance
  logic             cfg_we, arm, abort, trigger;
  logic [0:0]       cfg_addr;
  logic [CFG_W-1:0] cfg_wdata;
  logic             fire, busy, done, collision, overflow;
  logic [3:0]       fire_delay, fire_width, fired_cnt;
  logic [15:0]      cycle_cnt;

  // CYC_W=4 instance for the overflow case
  logic        arm4, trigger4;
  logic        fire4, busy4, done4, collision4, overflow4;
  logic [3:0]  fire_delay4, fire_width4, fired_cnt4, cycle_cnt4;

  glitch_scheduler dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .arm(arm), .abort(abort), .trigger(trigger),
    .fire(fire), .fire_delay(fire_delay), .fire_width(fire_width),
    .cycle_cnt(cycle_cnt), .busy(busy), .done(done), .fired_cnt(fired_cnt),
    .collision(collision), .overflow(overflow)
  );

  glitch_scheduler #(.NUM_SLOTS(2), .CYC_W(4), .TAP_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_we(1'b0), .cfg_addr(1'b0),
    .cfg_wdata(13'd0), .arm(arm4), .abort(1'b0), .trigger(trigger4),
    .fire(fire4), .fire_delay(fire_delay4), .fire_width(fire_width4),
    .cycle_cnt(cycle_cnt4), .busy(busy4), .done(done4), .fired_cnt(fired_cnt4),
    .collision(collision4), .overflow(overflow4)
  );

  int total = 0;
  int bad   = 0;
  int fire4_seen = 0;

  typedef struct {
    int cyc;
    int dly;
    int wid;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [CFG_W-1:0] mk(input logic en, input int cyc, input int dly, input int wid);
    slot_cfg_t c;
    c.en    = en;
    c.cycle = 16'(cyc);
    c.delay = 4'(dly);
    c.width = 4'(wid);
    return c;
  endfunction

  // Monitor: every fire strobe must match the oldest expected glitch.
  always @(negedge clk) begin
    if (fire) begin
      if (sb.size() == 0) begin
        check("unexpected_fire_at_cnt", 32'(cycle_cnt), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("fire_cycle", 32'(cycle_cnt), 32'(e.cyc));
        check("fire_delay", 32'(fire_delay), 32'(e.dly));
        check("fire_width", 32'(fire_width), 32'(e.wid));
      end
    end
    if (fire4) fire4_seen++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_slot(input int idx, input logic [CFG_W-1:0] w);
    cfg_we    = 1'b1;
    cfg_addr  = 1'(idx);
    cfg_wdata = w;
    step(1);
    cfg_we    = 1'b0;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    step(1);
    arm = 1'b0;
  endtask

  task automatic expect_fire(input int c, input int d, input int w);
    exp_t e;
    e.cyc = c; e.dly = d; e.wid = w;
    sb.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    arm = 1'b0; abort = 1'b0; trigger = 1'b0;
    arm4 = 1'b0; trigger4 = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);

    // Reset state
    check("rst_fire", 32'(fire), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cycle_cnt", 32'(cycle_cnt), 0);
    check("rst_fired_cnt", 32'(fired_cnt), 0);
    check("rst_taps", 32'({fire_delay, fire_width}), 0);

    // Scenario 1: two slots at 21 and 23, trigger high 40 cycles
    write_slot(0, mk(1'b1, 21, 1, 2));
    write_slot(1, mk(1'b1, 23, 3, 1));
    arm_pulse();
    check("s1_busy_armed", 32'(busy), 1);
    expect_fire(21, 1, 2);
    expect_fire(23, 3, 1);
    trigger = 1'b1;
    step(40);
    trigger = 1'b0;
    step(2);
    check("s1_done", 32'(done), 1);
    check("s1_busy", 32'(busy), 0);
    check("s1_cycle_cnt", 32'(cycle_cnt), 39);
    check("s1_fired_cnt", 32'(fired_cnt), 2);
    check("s1_collision", 32'(collision), 0);
    check("s1_overflow", 32'(overflow), 0);
    check("s1_sb_empty", 32'(sb.size()), 0);

    // Scenario 2: both slots at cycle 5
    write_slot(0, mk(1'b1, 5, 2, 6));
    write_slot(1, mk(1'b1, 5, 4, 3));
    arm_pulse();
    expect_fire(5, 2, 6);
    trigger = 1'b1;
    step(12);
    trigger = 1'b0;
    step(2);
    check("s2_collision", 32'(collision), 1);
    check("s2_fired_cnt", 32'(fired_cnt), 1);
    check("s2_cycle_cnt", 32'(cycle_cnt), 11);
    check("s2_sb_empty", 32'(sb.size()), 0);

    // Scenario 3: slot beyond trigger window
    write_slot(0, mk(1'b1, 30, 1, 1));
    write_slot(1, mk(1'b0, 2, 1, 1));
    arm_pulse();
    trigger = 1'b1;
    step(10);
    trigger = 1'b0;
    step(2);
    check("s3_done", 32'(done), 1);
    check("s3_cycle_cnt", 32'(cycle_cnt), 9);
    check("s3_fired_cnt", 32'(fired_cnt), 0);
    check("s3_collision_cleared", 32'(collision), 0);
    check("s3_sb_empty", 32'(sb.size()), 0);

    // Scenario 4: trigger high before arm; slot at cycle 0; trigger falls on
    // the cycle slot1 would match.
    write_slot(0, mk(1'b1, 0, 5, 5));
    write_slot(1, mk(1'b1, 4, 6, 6));
    trigger = 1'b1;
    step(2);
    arm_pulse();
    step(4);
    check("s4_still_armed_busy", 32'(busy), 1);
    check("s4_still_armed_cnt", 32'(cycle_cnt), 0);
    check("s4_no_fire_armed", 32'(fired_cnt), 0);
    trigger = 1'b0;
    step(2);
    expect_fire(0, 5, 5);
    trigger = 1'b1;
    step(1);
    check("s4_run_cnt0", 32'(cycle_cnt), 0);
    check("s4_run_busy", 32'(busy), 1);
    step(3);
    trigger = 1'b0;
    step(2);
    check("s4_done", 32'(done), 1);
    check("s4_cycle_cnt", 32'(cycle_cnt), 3);
    check("s4_fired_cnt", 32'(fired_cnt), 1);
    check("s4_sb_empty", 32'(sb.size()), 0);
    abort = 1'b1;
    arm = 1'b1;
    step(1);
    abort = 1'b0;
    arm = 1'b0;
    check("s4_abort_busy", 32'(busy), 0);
    check("s4_abort_done", 32'(done), 0);

    // Scenario 5: CYC_W=4, no enabled slot, trigger stays high
    arm4 = 1'b1;
    step(1);
    arm4 = 1'b0;
    trigger4 = 1'b1;
    step(20);
    check("s5_done", 32'(done4), 1);
    check("s5_cycle_cnt", 32'(cycle_cnt4), 15);
    check("s5_overflow", 32'(overflow4), 1);
    check("s5_fires", 32'(fire4_seen), 0);
    trigger4 = 1'b0;
    step(1);

    // Scenario 6: reset mid-run; cfg write during RUN ignored
    write_slot(0, mk(1'b1, 21, 1, 2));
    write_slot(1, mk(1'b1, 23, 3, 1));
    arm_pulse();
    expect_fire(21, 1, 2);
    trigger = 1'b1;
    step(11);
    check("s6_run_cnt", 32'(cycle_cnt), 10);
    write_slot(1, mk(1'b1, 12, 9, 9));
    begin
      int budget;
      budget = 100;
      while (cycle_cnt != 16'd22 && budget > 0) begin
        step(1);
        budget--;
      end
      check("s6_reach_cnt22_timeout", 32'(budget > 0), 1);
    end
    #1;
    rst_n = 1'b0;
    trigger = 1'b0;
    #1;
    check("s6_async_fire", 32'(fire), 0);
    check("s6_async_cnt", 32'(cycle_cnt), 0);
    check("s6_async_fired_cnt", 32'(fired_cnt), 0);
    check("s6_async_busy", 32'(busy), 0);
    check("s6_sb_empty", 32'(sb.size()), 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    arm_pulse();
    trigger = 1'b1;
    step(30);
    trigger = 1'b0;
    step(2);
    check("s6_post_done", 32'(done), 1);
    check("s6_post_fired_cnt", 32'(fired_cnt), 0);
    check("s6_post_cycle_cnt", 32'(cycle_cnt), 29);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
